// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 mouse packetizer.
package ps2_pkg;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_WAIT,
    TX_INHIBIT,
    TX_REQ,
    TX_BITS,
    TX_ACK,
    TX_REPLY,
    TX_DONE
  } tx_state_t;

  localparam logic [7:0]  CMD_ENABLE = 8'hF4;
  localparam logic [7:0]  RSP_ACK    = 8'hFA;
  localparam int unsigned FRAME_BITS = 11;
  localparam int unsigned MAX_RETRY  = 3;

endpackage

// File: rtl/ps2_line_filter.sv
// One PS/2 line: 2-FF synchronizer, stability filter and registered falling-edge strobe.
module ps2_line_filter #(
  parameter int unsigned FILTER_LEN = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic line_in,
  output logic line_out,
  output logic fall
);

  localparam int unsigned CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic [1:0]       sync;
  logic [CNT_W-1:0] cnt;

  // Filtered level only follows the synchronized line after FILTER_LEN differing cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync     <= 2'b11;
      line_out <= 1'b1;
      cnt      <= '0;
      fall     <= 1'b0;
    end else begin
      sync <= {sync[0], line_in};
      fall <= 1'b0;
      if (sync[1] == line_out) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(FILTER_LEN - 1)) begin
        line_out <= sync[1];
        cnt      <= '0;
        fall     <= line_out;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/ps2_mouse_packetizer.sv
// PS/2 mouse receiver assembling 3-byte packets onto the 25-bit ps2_mouse bus.
// Define PS2_MOUSE_HOST_INIT_EN to send the enable-reporting command after reset.
module ps2_mouse_packetizer
  import ps2_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned FILTER_LEN = 8,
  parameter int unsigned TIMEOUT_US = 2000,
  parameter int unsigned INIT_MS    = 100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ps2_clk_in,
  input  logic        ps2_data_in,
  output logic        ps2_clk_oe,
  output logic        ps2_data_oe,
  output logic [24:0] ps2_mouse,
  output logic        frame_err
);

  localparam longint unsigned TO_CYC = (longint'(TIMEOUT_US) * longint'(CLK_HZ)) / 64'd1_000_000;
  localparam int unsigned     TO_W   = $clog2(TO_CYC + 1);

  logic clk_lvl, clk_fall, data_lvl, data_fall;
  logic unused_ok;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
    .clk(clk), .reset(reset), .line_in(ps2_clk_in), .line_out(clk_lvl), .fall(clk_fall)
  );
  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filt (
    .clk(clk), .reset(reset), .line_in(ps2_data_in), .line_out(data_lvl), .fall(data_fall)
  );

  assign unused_ok = ^{clk_lvl, data_fall};

  rx_state_t       rx_state;
  logic [2:0]      bit_cnt;
  logic [7:0]      shreg;
  logic            par_bit;
  logic [TO_W-1:0] to_cnt;
  logic [1:0]      idx;
  logic [7:0]      b0, b1;
  logic            rx_en_c, pkt_en_c, stop_c, byte_ok_c;

  assign stop_c    = rx_en_c && (rx_state == RX_STOP) && clk_fall;
  assign byte_ok_c = (^{shreg, par_bit}) && data_lvl;

  // Frame receiver, edge timeout and packet assembler.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state  <= RX_IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      par_bit   <= 1'b0;
      to_cnt    <= '0;
      idx       <= '0;
      b0        <= '0;
      b1        <= '0;
      ps2_mouse <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      if (!rx_en_c) begin
        rx_state <= RX_IDLE;
        to_cnt   <= '0;
      end else if (clk_fall) begin
        to_cnt <= '0;
        unique case (rx_state)
          RX_IDLE: begin
            if (!data_lvl) begin
              rx_state <= RX_DATA;
              bit_cnt  <= '0;
            end
          end
          RX_DATA: begin
            shreg   <= {data_lvl, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) rx_state <= RX_PARITY;
          end
          RX_PARITY: begin
            par_bit  <= data_lvl;
            rx_state <= RX_STOP;
          end
          RX_STOP: begin
            rx_state <= RX_IDLE;
            if (!byte_ok_c) begin
              frame_err <= 1'b1;
              idx       <= '0;
            end else if (pkt_en_c) begin
              unique case (idx)
                2'd0: begin
                  // Bit 3 of the status byte is always set; use it to find packet alignment.
                  if (shreg[3]) begin
                    b0  <= shreg;
                    idx <= 2'd1;
                  end else begin
                    frame_err <= 1'b1;
                  end
                end
                2'd1: begin
                  b1  <= shreg;
                  idx <= 2'd2;
                end
                2'd2: begin
                  ps2_mouse <= {~ps2_mouse[24], shreg, b1, b0};
                  idx       <= '0;
                end
                default: idx <= '0;
              endcase
            end
          end
        endcase
      end else if (rx_state != RX_IDLE) begin
        if (to_cnt == TO_W'(TO_CYC - 1)) begin
          rx_state  <= RX_IDLE;
          to_cnt    <= '0;
          frame_err <= 1'b1;
          idx       <= '0;
        end else begin
          to_cnt <= to_cnt + TO_W'(1);
        end
      end
    end
  end

`ifdef PS2_MOUSE_HOST_INIT_EN
  localparam longint unsigned INIT_CYC = (longint'(INIT_MS) * longint'(CLK_HZ)) / 64'd1000;
  localparam longint unsigned INH_CYC  = (64'd100 * longint'(CLK_HZ)) / 64'd1_000_000;

  tx_state_t   tx_state;
  logic [31:0] tmr;
  logic [3:0]  tx_bit;
  logic [8:0]  tx_sh;
  logic [1:0]  tries;
  logic        tx_fail_c;

  assign rx_en_c  = !(tx_state inside {TX_INHIBIT, TX_REQ, TX_BITS, TX_ACK});
  assign pkt_en_c = (tx_state == TX_DONE);

  always_comb begin
    tx_fail_c = 1'b0;
    unique case (tx_state)
      TX_BITS:  tx_fail_c = !clk_fall && (tmr == 32'(TO_CYC - 1));
      TX_ACK:   tx_fail_c = clk_fall ? data_lvl : (tmr == 32'(TO_CYC - 1));
      TX_REPLY: tx_fail_c = stop_c ? !(byte_ok_c && shreg == RSP_ACK) : (tmr == 32'(INIT_CYC - 1));
      default:  tx_fail_c = 1'b0;
    endcase
  end

  // Host command sequencer: inhibit, request-to-send, clock out 0xF4, check ack and reply.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state    <= TX_IDLE;
      tmr         <= '0;
      tx_bit      <= '0;
      tx_sh       <= '0;
      tries       <= '0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
    end else if (tx_fail_c) begin
      ps2_data_oe <= 1'b0;
      tmr         <= '0;
      if (tries == 2'(MAX_RETRY - 1)) begin
        ps2_clk_oe <= 1'b0;
        tx_state   <= TX_DONE;
      end else begin
        tries      <= tries + 2'd1;
        ps2_clk_oe <= 1'b1;
        tx_state   <= TX_INHIBIT;
      end
    end else begin
      unique case (tx_state)
        TX_IDLE: begin
          tmr      <= '0;
          tx_state <= TX_WAIT;
        end
        TX_WAIT: begin
          if (tmr == 32'(INIT_CYC - 1)) begin
            tmr        <= '0;
            ps2_clk_oe <= 1'b1;
            tx_state   <= TX_INHIBIT;
          end else begin
            tmr <= tmr + 32'd1;
          end
        end
        TX_INHIBIT: begin
          if (tmr == 32'(INH_CYC - 1)) begin
            tmr         <= '0;
            ps2_data_oe <= 1'b1;
            tx_sh       <= {~^CMD_ENABLE, CMD_ENABLE};
            tx_bit      <= '0;
            tx_state    <= TX_REQ;
          end else begin
            tmr <= tmr + 32'd1;
          end
        end
        TX_REQ: begin
          ps2_clk_oe <= 1'b0;
          tx_state   <= TX_BITS;
        end
        TX_BITS: begin
          if (clk_fall) begin
            tmr    <= '0;
            tx_bit <= tx_bit + 4'd1;
            if (tx_bit == 4'(FRAME_BITS - 2)) begin
              ps2_data_oe <= 1'b0;
              tx_state    <= TX_ACK;
            end else begin
              ps2_data_oe <= ~tx_sh[0];
              tx_sh       <= {1'b0, tx_sh[8:1]};
            end
          end else begin
            tmr <= tmr + 32'd1;
          end
        end
        TX_ACK: begin
          if (clk_fall) begin
            tmr      <= '0;
            tx_state <= TX_REPLY;
          end else begin
            tmr <= tmr + 32'd1;
          end
        end
        TX_REPLY: begin
          if (stop_c) tx_state <= TX_DONE;
          else        tmr      <= tmr + 32'd1;
        end
        TX_DONE: tx_state <= TX_DONE;
      endcase
    end
  end
`else
  assign rx_en_c     = 1'b1;
  assign pkt_en_c    = 1'b1;
  assign ps2_clk_oe  = 1'b0;
  assign ps2_data_oe = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_mouse_packetizer.sv
// Directed bench for ps2_mouse_packetizer: device-side frame driver, packet scoreboard, error counting.
`timescale 1ns/1ps
module tb_ps2_mouse_packetizer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ps2_clk_in = 1'b1;
  logic        ps2_data_in = 1'b1;
  logic        ps2_clk_oe, ps2_data_oe;
  logic [24:0] ps2_mouse;
  logic        frame_err;

  always #500 clk = ~clk;

  ps2_mouse_packetizer #(
    .CLK_HZ(1_000_000), .FILTER_LEN(8), .TIMEOUT_US(2000), .INIT_MS(1)
  ) dut (
    .clk(clk), .reset(reset), .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe), .ps2_mouse(ps2_mouse),
    .frame_err(frame_err)
  );

  int          tests = 0;
  int          fails = 0;
  int          fe_cnt = 0;
  int          fe_exp = 0;
  logic        tog = 1'b0;
  logic [24:0] prev = '0;
  logic [24:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Output monitor: every ps2_mouse change must match the next expected packet.
  always @(negedge clk) begin
    if (reset) begin
      prev = ps2_mouse;
    end else begin
      if (frame_err === 1'b1) fe_cnt++;
      if (ps2_mouse !== prev) begin
        if (exp_q.size() == 0) check("unexpected_update", 32'(ps2_mouse), 32'(prev));
        else                   check("packet", 32'(ps2_mouse), 32'(exp_q.pop_front()));
        prev = ps2_mouse;
      end
    end
  end

  // Device-side frame; nbits < 11 stops clocking early.
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input int nbits, input bit glitch);
    logic [10:0] fr;
    fr = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk) ps2_data_in = fr[i];
      repeat (20) @(negedge clk);
      if (glitch) begin
        ps2_clk_in = 1'b0;
        @(negedge clk) ps2_clk_in = 1'b1;
      end
      repeat (20) @(negedge clk);
      ps2_clk_in = 1'b0;
      repeat (40) @(negedge clk);
      ps2_clk_in = 1'b1;
    end
    @(negedge clk) ps2_data_in = 1'b1;
    repeat (100) @(negedge clk);
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                          input bit glitch, input string tag);
    send_frame(b0, 1'b0, 11, glitch);
    send_frame(b1, 1'b0, 11, glitch);
    tog = ~tog;
    exp_q.push_back({tog, b2, b1, b0});
    send_frame(b2, 1'b0, 11, glitch);
    wait_drain(tag);
  endtask

  initial begin
    #100_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (5) @(negedge clk);
    check("reset_mouse", 32'(ps2_mouse), 32'd0);
    check("reset_frame_err", 32'(frame_err), 32'd0);
    check("reset_clk_oe", 32'(ps2_clk_oe), 32'd0);
    check("reset_data_oe", 32'(ps2_data_oe), 32'd0);
    reset = 1'b0;
    repeat (20) @(negedge clk);

    send_pkt(8'h08, 8'h05, 8'hFB, 1'b0, "pkt1_drain");
    check("pkt1_value", 32'(ps2_mouse), 32'h1FB0508);
    send_pkt(8'h08, 8'h05, 8'hFB, 1'b0, "pkt2_drain");
    check("pkt2_toggle", 32'(ps2_mouse[24]), 32'd0);
    check("fe_after_good", 32'(fe_cnt), 32'(fe_exp));

    // Byte 1 with bad parity restarts packet alignment.
    send_frame(8'h08, 1'b0, 11, 1'b0);
    send_frame(8'h05, 1'b1, 11, 1'b0);
    fe_exp++;
    check("fe_parity", 32'(fe_cnt), 32'(fe_exp));
    check("parity_hold", 32'(ps2_mouse), 32'h0FB0508);
    send_pkt(8'h08, 8'h05, 8'hFB, 1'b0, "pkt_after_parity");

    // Status byte without bit 3 is dropped.
    send_frame(8'h00, 1'b0, 11, 1'b0);
    fe_exp++;
    check("fe_sync", 32'(fe_cnt), 32'(fe_exp));
    send_pkt(8'h09, 8'h01, 8'h02, 1'b0, "pkt_after_sync");

    // Clocking stops after 5 bits; line idles for 3 ms.
    send_frame(8'h08, 1'b0, 5, 1'b0);
    repeat (2900) @(negedge clk);
    fe_exp++;
    check("fe_timeout", 32'(fe_cnt), 32'(fe_exp));
    send_pkt(8'h08, 8'h12, 8'h34, 1'b0, "pkt_after_timeout");

    send_pkt(8'h18, 8'h7F, 8'h80, 1'b1, "pkt_glitch");
    check("fe_glitch", 32'(fe_cnt), 32'(fe_exp));

    // Reset with one byte accepted and a second one half received.
    send_frame(8'h08, 1'b0, 11, 1'b0);
    send_frame(8'h28, 1'b0, 5, 1'b0);
    @(negedge clk) reset = 1'b1;
    repeat (3) @(negedge clk);
    check("midreset_mouse", 32'(ps2_mouse), 32'd0);
    check("midreset_frame_err", 32'(frame_err), 32'd0);
    tog = 1'b0;
    reset = 1'b0;
    repeat (20) @(negedge clk);
    send_pkt(8'h28, 8'h01, 8'h01, 1'b0, "pkt_after_reset");
    check("pkt_after_reset_value", 32'(ps2_mouse), 32'h1010128);
    check("fe_final", 32'(fe_cnt), 32'(fe_exp));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
